// File: rtl/spinner_mc.sv
// rtl/spinner_mc.sv - multi-channel spinner/paddle position accumulator
// Digital plus/minus steps on strobe rising edges plus toggle-flagged analog deltas.
module spinner_mc #(
  parameter int CH    = 2,
  parameter int W     = 4,
  parameter int F     = 2,
  parameter int FAST  = 2,
  parameter int CLAMP = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            strobe,
  input  logic [CH-1:0]   plus,
  input  logic [CH-1:0]   minus,
  input  logic [CH-1:0]   fast,
  input  logic [9*CH-1:0] spin_in,
  output logic [W*CH-1:0] spin_out,
  output logic [CH-1:0]   changed
);

  localparam int PW = W + F;
  // At least W+F+2 bits, widened so a full +/-128 analog delta on top of pos cannot overflow.
  localparam int SW = ((PW > 8) ? PW : 8) + 2;

  typedef logic signed [SW-1:0] sum_t;

  localparam sum_t MAXV = sum_t'((1 << PW) - 1);

  logic strobe_q, strobe_d;
  logic primed_q, primed_d;
  logic strobe_edge;

  always_comb begin
    strobe_d    = strobe;
    primed_d    = 1'b1;
    strobe_edge = primed_q & strobe & ~strobe_q;
  end

  // strobe history resets high so a strobe already asserted at release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b1;
      primed_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      primed_q <= primed_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [PW-1:0]     pos_q, pos_d;
    logic              tog_q, tog_d;
    logic              changed_q, changed_d;
    logic signed [7:0] raw;
    sum_t              step, dig, ana, sum;

    always_comb begin
      tog_d = spin_in[9*i+8];
      raw   = spin_in[9*i +: 8];
      step  = fast[i] ? (sum_t'(1) << FAST) : sum_t'(1);

      dig = '0;
      if (strobe_edge && plus[i] && !minus[i]) begin
        dig = step;
      end else if (strobe_edge && minus[i] && !plus[i]) begin
        dig = -step;
      end

      ana = '0;
      if (primed_q && (spin_in[9*i+8] != tog_q)) begin
        ana = sum_t'(raw);
      end

      sum = sum_t'(pos_q) + dig + ana;

      if ((CLAMP != 0) && (sum < 0)) begin
        pos_d = '0;
      end else if ((CLAMP != 0) && (sum > MAXV)) begin
        pos_d = '1;
      end else begin
        pos_d = sum[PW-1:0];
      end

      changed_d = (pos_d[PW-1:F] != pos_q[PW-1:F]);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pos_q     <= '0;
        tog_q     <= 1'b0;
        changed_q <= 1'b0;
      end else begin
        pos_q     <= pos_d;
        tog_q     <= tog_d;
        changed_q <= changed_d;
      end
    end

    assign spin_out[W*i +: W] = pos_q[PW-1:F];
    assign changed[i]         = changed_q;
  end

endmodule

// File: tb/tb_spinner_mc.sv
// tb/tb_spinner_mc.sv - scoreboard bench for spinner_mc (wrap and clamp instances)
module tb_spinner_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe0 = 1'b0, strobe1 = 1'b0;
  logic [1:0]  plus0 = '0, minus0 = '0, fast0 = '0;
  logic [1:0]  plus1 = '0, minus1 = '0, fast1 = '0;
  logic [17:0] spin0 = '0, spin1 = '0;
  logic [7:0]  out0, out1;
  logic [1:0]  chg0, chg1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q [4][$];

  always #5 clk = ~clk;

  spinner_mc #(.CH(2), .W(4), .F(2), .FAST(2), .CLAMP(0)) u_wrap (
    .clk(clk), .reset(reset), .strobe(strobe0), .plus(plus0), .minus(minus0),
    .fast(fast0), .spin_in(spin0), .spin_out(out0), .changed(chg0)
  );

  spinner_mc #(.CH(2), .W(4), .F(2), .FAST(2), .CLAMP(1)) u_clamp (
    .clk(clk), .reset(reset), .strobe(strobe1), .plus(plus1), .minus(minus1),
    .fast(fast1), .spin_in(spin1), .spin_out(out1), .changed(chg1)
  );

  wire [3:0]  chg_all = {chg1, chg0};
  wire [15:0] out_all = {out1, out0};

  // Monitor: every changed pulse must match the next queued angle for that instance/channel.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (chg_all[k]) begin
          n_tests++;
          if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL pulse_k%0d: unexpected changed pulse, angle %0d, none required", k, out_all[4*k +: 4]);
          end else begin
            int e;
            e = exp_q[k].pop_front();
            if (out_all[4*k +: 4] != e[3:0]) begin
              n_fail++;
              $display("FAIL pulse_k%0d: angle %0d, required %0d", k, out_all[4*k +: 4], e);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input bit which, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (which) strobe1 = 1'b1; else strobe0 = 1'b1;
      @(negedge clk);
      if (which) strobe1 = 1'b0; else strobe0 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle(2);
    check("reset_out0", out0, 0);
    check("reset_out1", out1, 0);
    check("reset_chg0", chg0, 0);
    check("reset_chg1", chg1, 0);
    reset = 1'b0;
    idle(2);

    // Slow plus, 8 strobes: 8 quarter-steps = angle 2, pulses at angles 1 and 2.
    plus0 = 2'b01;
    exp_q[0].push_back(1);
    exp_q[0].push_back(2);
    pulse(0, 8);
    plus0 = '0;
    check("slow8_ch0", out0[3:0], 2);
    check("slow8_ch1", out0[7:4], 0);

    // Fast plus, 3 strobes: +4 each -> angle 3.
    do_reset();
    plus0 = 2'b01; fast0 = 2'b01;
    exp_q[0].push_back(1);
    exp_q[0].push_back(2);
    exp_q[0].push_back(3);
    pulse(0, 3);
    plus0 = '0;
    check("fast3_ch0", out0[3:0], 3);

    // Fast minus from 0 wraps to pos 60 -> angle 15.
    do_reset();
    minus0 = 2'b01;
    exp_q[0].push_back(15);
    pulse(0, 1);
    minus0 = '0; fast0 = '0;
    check("wrap_ch0", out0[3:0], 15);

    // Analog toggles: +12 -> 3, -8 -> 1, +1 -> still 1 with no pulse.
    do_reset();
    exp_q[0].push_back(3);
    @(negedge clk); spin0[8:0] = {1'b1, 8'd12};
    @(negedge clk); check("ana_p12", out0[3:0], 3);
    exp_q[0].push_back(1);
    spin0[8:0] = {1'b0, 8'hF8};
    @(negedge clk); check("ana_m8", out0[3:0], 1);
    spin0[8:0] = {1'b1, 8'd1};
    idle(3);
    check("ana_p1", out0[3:0], 1);
    check("ana_ch1", out0[7:4], 0);

    // Strobe fast +4 and analog -4 in the same cycle cancel.
    @(negedge clk);
    plus0 = 2'b01; fast0 = 2'b01; strobe0 = 1'b1;
    spin0[8:0] = {1'b0, 8'hFC};
    @(negedge clk);
    strobe0 = 1'b0; plus0 = '0; fast0 = '0;
    idle(3);
    check("cancel_ch0", out0[3:0], 1);

    // Strobe held high with plus changing: only one step.
    do_reset();
    spin0 = '0;
    @(negedge clk); plus0 = 2'b01; fast0 = 2'b01; strobe0 = 1'b1;
    exp_q[0].push_back(1);
    idle(2); plus0 = '0; idle(2); plus0 = 2'b01; idle(3);
    strobe0 = 1'b0; plus0 = '0; fast0 = '0;
    idle(2);
    check("held_ch0", out0[3:0], 1);

    // Reset released with toggle bits and strobe high: nothing moves.
    @(negedge clk);
    reset = 1'b1;
    spin0 = {1'b1, 8'd40, 1'b1, 8'd40};
    spin1 = {1'b1, 8'd40, 1'b1, 8'd40};
    strobe0 = 1'b1; strobe1 = 1'b1;
    plus0 = 2'b11; plus1 = 2'b11;
    idle(2);
    reset = 1'b0;
    idle(4);
    check("rel_out0", out0, 0);
    check("rel_out1", out1, 0);
    strobe0 = 1'b0; strobe1 = 1'b0; plus0 = '0; plus1 = '0;
    idle(3);

    // Clamp instance: minus at 0 stays 0, then fast plus saturates at 15.
    do_reset();
    minus1 = 2'b01;
    pulse(1, 1);
    minus1 = '0;
    check("clamp_lo", out1[3:0], 0);
    plus1 = 2'b01; fast1 = 2'b01;
    for (int a = 1; a <= 15; a++) exp_q[2].push_back(a);
    pulse(1, 15);
    check("clamp_15th", out1[3:0], 15);
    pulse(1, 5);
    plus1 = '0; fast1 = '0;
    check("clamp_hi", out1[3:0], 15);
    check("clamp_ch1", out1[7:4], 0);

    idle(3);
    for (int k = 0; k < 4; k++) check($sformatf("leftover_k%0d", k), exp_q[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spinner_mc.md
SPINNER_MC -- requirements
Module: spinner_mc

Interface
REQ-001 SHALL have parameter CH, default 2, number of independent spinner channels (1..8).
REQ-002 SHALL have parameter W, default 4, width of integer angle output per channel (2..12).
REQ-003 SHALL have parameter F, default 2, fractional bits of internal position; digital slow step = 1 LSB of fraction.
REQ-004 SHALL have parameter FAST, default 2, left-shift applied to digital step when fast asserted (FAST <= W+F-1).
REQ-005 SHALL have parameter CLAMP, default 0; 0 = modular wrap, 1 = saturate at 0 and 2^(W+F)-1.
REQ-006 SHALL have port clk  input  1  system clock; all logic in this single domain.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port strobe  input  1  frame tick (vsync); only its rising edge is used.
REQ-009 SHALL have port plus  input  CH  per-channel clockwise digital request, level.
REQ-010 SHALL have port minus  input  CH  per-channel counter-clockwise digital request, level.
REQ-011 SHALL have port fast  input  CH  per-channel fast-step select, level.
REQ-012 SHALL have port spin_in  input  9*CH  per-channel analog spinner: bit 8 toggles per new sample, bits 7:0 signed delta in fraction LSBs.
REQ-013 SHALL have port spin_out  output  W*CH  per-channel angle = pos[W+F-1:F].
REQ-014 SHALL have port changed  output  CH  one-cycle pulse when a channel's spin_out value changes.

Function
REQ-015 SHALL keep per channel a W+F-bit position register pos, a toggle history bit tog_d, and a primed flag; plus one shared strobe history bit strobe_d.
REQ-016 SHALL detect strobe edge as strobe=1 with strobe_d=0 at a rising clk edge; strobe_d <= strobe every cycle.
REQ-017 SHALL form digital delta per channel on a strobe edge: +step if plus&~minus, -step if minus&~plus, 0 if both or neither; step = 1, or 1<<FAST when fast=1.
REQ-018 SHALL form analog delta per channel as sign-extended spin_in[7:0] when primed=1 and spin_in[8] != tog_d, else 0; tog_d <= spin_in[8] every cycle.
REQ-019 SHALL set primed <= 1 on the first clk edge after reset release; events are not taken while primed=0 (no spurious event from a toggle bit already high at reset).
REQ-020 SHALL apply digital and analog deltas of the same cycle in one addition, computed at W+F+2 bits signed, then wrapped (CLAMP=0) or saturated (CLAMP=1).
REQ-021 SHALL update pos on the same clk edge that sees the event; spin_out is a direct slice of pos (zero additional latency).
REQ-022 SHALL assert changed[i] for exactly the one cycle after the edge on which spin_out[i] took a new value; no pulse when saturation or a sub-LSB delta leaves the angle unchanged.
REQ-023 SHALL process all channels in parallel and independently; a channel's inputs never affect another channel.
REQ-024 SHALL ignore strobe held high (one step per rising edge only), regardless of plus/minus changes while high.

Reset
REQ-025 SHALL, while reset=1, force pos=0, spin_out=0, changed=0, primed=0, strobe_d=1 (a strobe high at reset release gives no edge), tog_d=0.
REQ-026 SHALL resume normal operation on the first clk edge after reset falls; reset mid-operation discards all accumulated position.

Verification
REQ-027 SHALL pass: W=4,F=2, plus[0]=1, fast=0, 8 strobe pulses -> spin_out[0]=2, changed[0] pulsed twice; channel 1 stays 0.
REQ-028 SHALL pass: fast[0]=1, plus[0]=1, 3 strobes -> spin_out[0]=3; then minus[0]=1 only from 0 with 1 fast strobe under CLAMP=0 -> 15.
REQ-029 SHALL pass: CLAMP=1, minus at pos 0 -> stays 0, no changed pulse; fast plus 20 strobes -> 15 after 15th, no further change or pulse.
REQ-030 SHALL pass: spin_in[0] toggle with delta +12 -> spin_out[0]=3 on next cycle; toggle with delta -8 -> 1; delta +1 toggle -> angle unchanged, no pulse.
REQ-031 SHALL pass: toggle event and strobe edge in same cycle, plus fast (+4) and delta -4 -> pos unchanged, no changed pulse.
REQ-032 SHALL pass: reset released with spin_in[8]=1 and strobe=1 -> spin_out stays 0 for all channels, no changed pulse.
